// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, 8 data bits LSB-first, parity bit or CRC-8 byte, stop bit(s).
// Define UART_TX_BREAK_EN to add the break_i input and the TX_BREAK line-hold state.
module uart_tx_frame #(
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       trigger_i,
    input  logic       crc_en_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
`ifdef UART_TX_BREAK_EN
    input  logic       break_i,
`endif
    output logic       data_ready_o,
    output logic       tx_o,
    output logic       is_tx_idle_o,
    output logic       frame_done_o
);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_CRC,
        TX_STOP
`ifdef UART_TX_BREAK_EN
        , TX_BREAK
`endif
    } txState_t;

    localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

    txState_t   r_state;
    logic [7:0] r_hold;
    logic       r_holdValid;
    logic [7:0] r_shift;
    logic [7:0] r_crc;
    logic       r_crcMode;
    logic       r_parity;
    logic [2:0] r_bitCnt;
    logic [1:0] r_stopCnt;
    logic       r_tx;
    logic       r_frameDone;

    logic       w_load;
    logic [7:0] w_crcNext;

    // A frame is loaded from the holding register either from idle or straight out of the last stop bit.
    always_comb begin
        w_load = 1'b0;
        if (trigger_i && r_holdValid) begin
            if (r_state == TX_IDLE) begin
                w_load = 1'b1;
            end else if (r_state == TX_STOP && r_stopCnt == STOP_LAST) begin
                w_load = 1'b1;
            end
        end
`ifdef UART_TX_BREAK_EN
        if (r_state == TX_IDLE && break_i) begin
            w_load = 1'b0;
        end
`endif
    end

    assign w_crcNext = {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ r_shift[0]) ? 8'h07 : 8'h00);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= TX_IDLE;
            r_hold      <= 8'h00;
            r_holdValid <= 1'b0;
            r_shift     <= 8'h00;
            r_crc       <= 8'h00;
            r_crcMode   <= 1'b0;
            r_parity    <= 1'b0;
            r_bitCnt    <= 3'd0;
            r_stopCnt   <= 2'd0;
            r_tx        <= 1'b1;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            // Parity is captured at load because the shift register is empty by the parity slot.
            if (w_load) begin
                r_shift     <= r_hold;
                r_holdValid <= 1'b0;
                r_crcMode   <= crc_en_i;
                r_crc       <= 8'h00;
                r_bitCnt    <= 3'd0;
                r_parity    <= (^r_hold) ^ PARITY_ODD;
            end else if (data_valid_i && !r_holdValid) begin
                r_hold      <= data_i;
                r_holdValid <= 1'b1;
            end

            if (trigger_i) begin
                case (r_state)
                    TX_IDLE: begin
`ifdef UART_TX_BREAK_EN
                        if (break_i) begin
                            r_state <= TX_BREAK;
                            r_tx    <= 1'b0;
                        end else
`endif
                        if (w_load) begin
                            r_state <= TX_START;
                            r_tx    <= 1'b0;
                        end
                    end
                    TX_START: begin
                        r_state <= TX_DATA;
                        r_tx    <= r_shift[0];
                    end
                    TX_DATA: begin
                        r_shift <= r_shift >> 1;
                        r_crc   <= w_crcNext;
                        if (r_bitCnt == 3'd7) begin
                            r_bitCnt <= 3'd0;
                            if (r_crcMode) begin
                                r_state <= TX_CRC;
                                r_tx    <= w_crcNext[7];
                            end else begin
                                r_state <= TX_PARITY;
                                r_tx    <= r_parity;
                            end
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                            r_tx     <= r_shift[1];
                        end
                    end
                    TX_PARITY: begin
                        r_state   <= TX_STOP;
                        r_stopCnt <= 2'd0;
                        r_tx      <= 1'b1;
                    end
                    // CRC goes out MSB first; the bit after bit_cnt is crc[6 - bit_cnt].
                    TX_CRC: begin
                        if (r_bitCnt == 3'd7) begin
                            r_state   <= TX_STOP;
                            r_stopCnt <= 2'd0;
                            r_tx      <= 1'b1;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                            r_tx     <= r_crc[3'd6 - r_bitCnt];
                        end
                    end
                    TX_STOP: begin
                        if (r_stopCnt == STOP_LAST) begin
                            r_frameDone <= 1'b1;
                            r_stopCnt   <= 2'd0;
                            if (w_load) begin
                                r_state <= TX_START;
                                r_tx    <= 1'b0;
                            end else begin
                                r_state <= TX_IDLE;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_stopCnt <= r_stopCnt + 2'd1;
                        end
                    end
`ifdef UART_TX_BREAK_EN
                    TX_BREAK: begin
                        if (!break_i) begin
                            r_state <= TX_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        r_state <= TX_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign data_ready_o = ~r_holdValid;
    assign tx_o         = r_tx;
    assign is_tx_idle_o = (r_state == TX_IDLE);
    assign frame_done_o = r_frameDone;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: a line monitor decodes frames and compares them
// against a scoreboard queue filled at byte acceptance. Break tests run with UART_TX_BREAK_EN.
module tb_uart_tx_frame;

    typedef struct {
        logic [19:0] bits;
        int          len;
    } frame_t;

    typedef struct {
        logic [7:0]  data;
        logic        crcEn;
        logic [19:0] bits;
        int          len;
    } vec_t;

    logic       clk;
    logic       rstN;
    logic       trigger;
    logic       crcEn;
    logic [7:0] data;
    logic       valid;
    logic       valid2;
    logic       brk;
    logic       ready, tx, idle, frameDone;
    logic       ready2, tx2, idle2, frameDone2;

    int         checks;
    int         failures;
    int         doneCnt;
    int         done2Cnt;
    int         trigCnt;
    logic       monEn;
    frame_t     expQ[$];
    int         gapQ[$];
    vec_t       vecs[6];

    uart_tx_frame #(.PARITY_ODD(1'b0), .STOP_BITS(1)) dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .trigger_i    (trigger),
        .crc_en_i     (crcEn),
        .data_i       (data),
        .data_valid_i (valid),
`ifdef UART_TX_BREAK_EN
        .break_i      (brk),
`endif
        .data_ready_o (ready),
        .tx_o         (tx),
        .is_tx_idle_o (idle),
        .frame_done_o (frameDone)
    );

    uart_tx_frame #(.PARITY_ODD(1'b1), .STOP_BITS(2)) dut2 (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .trigger_i    (trigger),
        .crc_en_i     (1'b0),
        .data_i       (data),
        .data_valid_i (valid2),
`ifdef UART_TX_BREAK_EN
        .break_i      (1'b0),
`endif
        .data_ready_o (ready2),
        .tx_o         (tx2),
        .is_tx_idle_o (idle2),
        .frame_done_o (frameDone2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock trigger strobe every 16 clocks, changed on the falling edge.
    initial begin
        trigger = 1'b0;
        trigCnt = 0;
        forever begin
            @(negedge clk);
            trigCnt = (trigCnt + 1) % 16;
            trigger = (trigCnt == 15);
        end
    end

    initial begin
        doneCnt  = 0;
        done2Cnt = 0;
        forever begin
            @(posedge clk);
            if (frameDone)  doneCnt++;
            if (frameDone2) done2Cnt++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired got=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("[TB] FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    function automatic void buildFrame(input logic [7:0] d, input logic c,
                                       output logic [19:0] bits, output int len);
        logic [7:0] crc;
        logic       fb;
        bits = 20'd0;
        crc  = 8'h00;
        bits = {bits[18:0], 1'b0};
        len  = 1;
        for (int i = 0; i < 8; i++) begin
            bits = {bits[18:0], d[i]};
            len++;
            fb   = crc[7] ^ d[i];
            crc  = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        if (c) begin
            for (int i = 7; i >= 0; i--) begin
                bits = {bits[18:0], crc[i]};
                len++;
            end
        end else begin
            bits = {bits[18:0], ^d};
            len++;
        end
        bits = {bits[18:0], 1'b1};
        len++;
    endfunction

    task automatic waitTrig();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!trigger && n < 64);
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!ready) checkOutput("readyTimeout", 32'(ready), 32'd1);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (!idle && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!idle) checkOutput("idleTimeout", 32'(idle), 32'd1);
    endtask

    // Present one byte, wait (bounded) for acceptance and queue the expected frame.
    task automatic applyStimulus(input logic [7:0] d, input logic c, input logic [19:0] eb,
                                 input int el, output int waited);
        frame_t f;
        @(negedge clk);
        crcEn  = c;
        data   = d;
        valid  = 1'b1;
        waited = 0;
        while (!ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            checkOutput("acceptTimeout", 32'(ready), 32'd1);
        end else begin
            f.bits = eb;
            f.len  = el;
            expQ.push_back(f);
            @(posedge clk);
        end
        @(negedge clk);
        valid = 1'b0;
        data  = 8'($urandom);
    endtask

    // Line monitor: samples mid bit period, frames start on a low sample.
    initial begin : lineMonitor
        logic        s;
        logic [19:0] got;
        int          n;
        int          idleRun;
        logic        inFrame;
        frame_t      exp;
        inFrame = 1'b0;
        idleRun = 0;
        n       = 0;
        got     = 20'd0;
        exp.bits = 20'd0;
        exp.len  = 0;
        forever begin
            @(posedge clk);
            if (!trigger) continue;
            repeat (8) @(negedge clk);
            if (!monEn) begin
                inFrame = 1'b0;
                idleRun = 0;
                continue;
            end
            s = tx;
            if (!inFrame) begin
                if (s == 1'b0) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedStart", 32'(s), 32'd1);
                    end else begin
                        exp     = expQ.pop_front();
                        inFrame = 1'b1;
                        got     = 20'd0;
                        n       = 0;
                        gapQ.push_back(idleRun);
                        idleRun = 0;
                    end
                end else begin
                    idleRun++;
                end
            end
            if (inFrame) begin
                got = {got[18:0], s};
                n++;
                if (n == exp.len) begin
                    checkOutput("frameBits", 32'(got), 32'(exp.bits));
                    inFrame = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [19:0] eb;
        int          el;
        int          waited;
        int          d0;
        logic [19:0] got;

        checks   = 0;
        failures = 0;
        rstN     = 1'b0;
        crcEn    = 1'b0;
        data     = 8'h00;
        valid    = 1'b0;
        valid2   = 1'b0;
        brk      = 1'b0;
        monEn    = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 20'b01010010101, 11};
        vecs[1] = '{8'h01, 1'b1, 20'b010000000100010011, 18};
        vecs[2] = '{8'h00, 1'b0, 20'd0, 0};
        vecs[3] = '{8'hFF, 1'b1, 20'd0, 0};
        vecs[4] = '{8'h3C, 1'b1, 20'd0, 0};
        vecs[5] = '{8'h80, 1'b0, 20'd0, 0};
        for (int i = 2; i < 6; i++) begin
            buildFrame(vecs[i].data, vecs[i].crcEn, eb, el);
            vecs[i].bits = eb;
            vecs[i].len  = el;
        end

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("resetTx", 32'(tx), 32'd1);
        checkOutput("resetReady", 32'(ready), 32'd1);
        checkOutput("resetIdle", 32'(idle), 32'd1);
        checkOutput("resetDone", 32'(frameDone), 32'd0);
        rstN  = 1'b1;
        monEn = 1'b1;

        $display("[TB] table frames");
        for (int i = 0; i < 6; i++) begin
            d0 = doneCnt;
            applyStimulus(vecs[i].data, vecs[i].crcEn, vecs[i].bits, vecs[i].len, waited);
            waitReady();
            crcEn = ~vecs[i].crcEn;
            waitIdle();
            repeat (2) @(negedge clk);
            checkOutput("doneCount", 32'(doneCnt - d0), 32'd1);
        end

        $display("[TB] back-to-back frames");
        gapQ.delete();
        d0    = doneCnt;
        crcEn = 1'b0;
        buildFrame(8'h3C, 1'b0, eb, el);
        applyStimulus(8'h3C, 1'b0, eb, el, waited);
        waitReady();
        buildFrame(8'hC3, 1'b0, eb, el);
        applyStimulus(8'hC3, 1'b0, eb, el, waited);
        checkOutput("readyLowHeld", 32'(ready), 32'd0);
        buildFrame(8'h5A, 1'b0, eb, el);
        applyStimulus(8'h5A, 1'b0, eb, el, waited);
        checkOutput("thirdStalled", 32'(waited >= 150), 32'd1);
        waitIdle();
        repeat (2) @(negedge clk);
        checkOutput("gapCount", 32'(gapQ.size()), 32'd3);
        checkOutput("gapSecond", 32'(gapQ.size() > 1 ? gapQ[1] : -1), 32'd0);
        checkOutput("gapThird", 32'(gapQ.size() > 2 ? gapQ[2] : -1), 32'd0);
        checkOutput("b2bDoneCount", 32'(doneCnt - d0), 32'd3);

        $display("[TB] two stop bits, odd parity");
        d0 = done2Cnt;
        @(negedge clk);
        data   = 8'hFF;
        valid2 = 1'b1;
        waited = 0;
        while (!ready2 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        valid2 = 1'b0;
        got    = 20'd0;
        for (int i = 0; i < 12; i++) begin
            waitTrig();
            repeat (8) @(negedge clk);
            got = {got[18:0], tx2};
            if (i == 11) checkOutput("idleInStop2", 32'(idle2), 32'd0);
        end
        checkOutput("stop2Frame", 32'(got), 32'b011111111111);
        waitTrig();
        repeat (8) @(negedge clk);
        checkOutput("idleAfterStop2", 32'(idle2), 32'd1);
        checkOutput("stop2DoneCount", 32'(done2Cnt - d0), 32'd1);

        $display("[TB] reset mid-frame");
        monEn = 1'b0;
        applyStimulus(8'h0F, 1'b0, 20'd0, 0, waited);
        waitReady();
        applyStimulus(8'hAA, 1'b0, 20'd0, 0, waited);
        checkOutput("pendingHeld", 32'(ready), 32'd0);
        repeat (5) waitTrig();
        repeat (3) @(negedge clk);
        checkOutput("bit4Line", 32'(tx), 32'd0);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midResetTx", 32'(tx), 32'd1);
        checkOutput("midResetIdle", 32'(idle), 32'd1);
        checkOutput("midResetReady", 32'(ready), 32'd1);
        rstN = 1'b1;
        expQ.delete();
        for (int i = 0; i < 3; i++) begin
            waitTrig();
            repeat (8) @(negedge clk);
            checkOutput("postResetLine", 32'(tx), 32'd1);
        end
        monEn = 1'b1;

`ifdef UART_TX_BREAK_EN
        $display("[TB] break with pending byte");
        monEn = 1'b0;
        @(negedge clk);
        brk = 1'b1;
        buildFrame(8'h55, 1'b0, eb, el);
        applyStimulus(8'h55, 1'b0, eb, el, waited);
        for (int i = 0; i < 3; i++) begin
            waitTrig();
            repeat (8) @(negedge clk);
            checkOutput("breakLine", 32'(tx), 32'd0);
        end
        brk = 1'b0;
        waitTrig();
        repeat (8) @(negedge clk);
        checkOutput("breakReleaseLine", 32'(tx), 32'd1);
        checkOutput("breakPendingHeld", 32'(ready), 32'd0);
        monEn = 1'b1;
        waitTrig();
        repeat (2) @(negedge clk);
        waitIdle();
        repeat (2) @(negedge clk);
`endif

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
